// File: rtl/mindfocus_pkg.sv
// Shared definitions for the MindFocus button front-end and game FSM.
// Holds the conditioning FSM state codes, the default button count and
// the one-hot check used both here and by jogo_mindfocus.
package mindfocus_pkg;

  // Default number of physical button lines on the board.
  localparam int N_BOTOES_DEF = 4;

  // Conditioning FSM states; the codes are exported on db_estado for debug.
  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRANDO     = 3'd1,
    REGISTRA      = 3'd2,
    ESPERA_SOLTAR = 3'd3
  } estado_t;

  // True when exactly one bit is set. Callers zero-extend narrower vectors
  // to 32 bits, so one function serves every button count up to 32.
  function automatic logic eh_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Purpose: multi-flop synchroniser that brings asynchronous lines into the clock domain.
// Latency: STAGES clock edges from an input change to the output.
// Backpressure: none; it samples every cycle and never stalls.
module sincronizador #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // cadeia[0] takes the raw input; cadeia[STAGES-1] is the synchronised output.
  logic [WIDTH-1:0] cadeia [STAGES];

  // Shift the input down the flop chain; reset clears every stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        cadeia[i] <= '0;
      end
    end else begin
      cadeia[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        cadeia[i] <= cadeia[i-1];
      end
    end
  end

  assign q = cadeia[STAGES-1];

endmodule

// File: rtl/condiciona_botoes.sv
// Purpose: synchronise and debounce the buttons, validate one-hot plays, run the inactivity timeout.
// Latency: tem_jogada rises SYNC_STAGES+DEBOUNCE_CYCLES edges after the press reaches the first flop.
// Backpressure: none; a press is consumed once and a held button never repeats until released.
module condiciona_botoes
  import mindfocus_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic                zera_timeout,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] jogada,
  output logic                tem_jogada,
  output logic                multipla,
  output logic                timeout,
  output logic [2:0]          db_estado
);

  // The debounce counter only ever reaches DEBOUNCE_CYCLES-1 before it is
  // cleared, so this width can never wrap.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_FIM  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [N_BOTOES-1:0] s;
  logic [N_BOTOES-1:0] amostra;
  logic [N_BOTOES-1:0] amostra_prox;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_prox;
  estado_t             estado;
  estado_t             estado_prox;

  logic                amostra_one_hot;
  logic [N_BOTOES-1:0] jogada_prox;
  logic                tem_prox;
  logic                mult_prox;

  logic [TO_W-1:0]     to_cnt;

  // Raw lines are asynchronous to clock; nothing downstream sees them unsynchronised.
  sincronizador #(
    .WIDTH  (N_BOTOES),
    .STAGES (SYNC_STAGES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // Captured pattern and debounce counter that travel with the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      amostra <= '0;
      cnt     <= '0;
    end else begin
      amostra <= amostra_prox;
      cnt     <= cnt_prox;
    end
  end

  // Next-state logic: filter the press, emit once, then wait for a clean release.
  always_comb begin
    estado_prox  = estado;
    amostra_prox = amostra;
    cnt_prox     = cnt;
    unique case (estado)
      OCIOSO: begin
        if (s != '0) begin
          estado_prox  = FILTRANDO;
          amostra_prox = s;
          cnt_prox     = '0;
        end
      end
      FILTRANDO: begin
        if (s != amostra) begin
          // Pattern moved before it settled: treat it as a glitch.
          estado_prox = OCIOSO;
          cnt_prox    = '0;
        end else if (cnt == CNT_FIM) begin
          estado_prox = REGISTRA;
          cnt_prox    = '0;
        end else begin
          cnt_prox = cnt + 1'b1;
        end
      end
      REGISTRA: begin
        estado_prox = ESPERA_SOLTAR;
        cnt_prox    = '0;
      end
      ESPERA_SOLTAR: begin
        // Any bounce back to pressed restarts the release window.
        if (s != '0) begin
          cnt_prox = '0;
        end else if (cnt == CNT_FIM) begin
          estado_prox = OCIOSO;
          cnt_prox    = '0;
        end else begin
          cnt_prox = cnt + 1'b1;
        end
      end
      default: begin
        estado_prox = OCIOSO;
        cnt_prox    = '0;
      end
    endcase
  end

  assign amostra_one_hot = eh_one_hot(32'(amostra));

  // Output decode: the pulses are set on the edge that enters REGISTRA, so
  // they are high exactly for the REGISTRA cycle and never both at once.
  always_comb begin
    tem_prox    = 1'b0;
    mult_prox   = 1'b0;
    jogada_prox = jogada;
    if ((estado_prox == REGISTRA) && habilita) begin
      if (amostra_one_hot) begin
        tem_prox    = 1'b1;
        jogada_prox = amostra;
      end else begin
        mult_prox = 1'b1;
      end
    end
  end

  // Registered outputs; jogada keeps the last accepted play until replaced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogada     <= '0;
      tem_jogada <= 1'b0;
      multipla   <= 1'b0;
    end else begin
      jogada     <= jogada_prox;
      tem_jogada <= tem_prox;
      multipla   <= mult_prox;
    end
  end

  // Inactivity timer: explicit clear beats an accepted play, which beats the
  // terminal count, so a play landing on the last cycle still avoids timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (zera_timeout) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (tem_jogada) begin
      to_cnt <= '0;
    end else if (habilita && !timeout) begin
      if (to_cnt == TO_FIM) begin
        timeout <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_condiciona_botoes.sv
// Bench for condiciona_botoes: directed scenarios plus randomized presses.
// Expected pulses are queued when a press is issued and popped by a monitor.
// Timeout and reset behaviour are checked at precise cycle counts.
`timescale 1us/1ns
module tb_condiciona_botoes;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic       zera_timeout;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       multipla;
  logic       timeout;
  logic [2:0] db_estado;

  condiciona_botoes dut (
    .clock        (clock),
    .reset        (reset),
    .habilita     (habilita),
    .zera_timeout (zera_timeout),
    .botoes       (botoes),
    .jogada       (jogada),
    .tem_jogada   (tem_jogada),
    .multipla     (multipla),
    .timeout      (timeout),
    .db_estado    (db_estado)
  );

  // 1 kHz clock.
  always #500 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // One expected output event: a play (tem=1, with its code) or a multi-press.
  typedef struct {
    bit       tem;
    logic [3:0] v;
    int       cyc;
  } ev_t;

  ev_t        fila[$];
  logic [3:0] ref_jogada = 4'd0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_cyc(input int alvo);
    while (cyc < alvo) @(negedge clock);
    #2;
  endtask

  // Reference rule: a press held long enough is accepted six edges after it
  // is applied; enabled one-hot codes are plays, enabled multi-bit codes are
  // multi-press pulses, disabled presses produce nothing.
  task automatic preve(input logic [3:0] v, input int len, input int inicio);
    ev_t e;
    if (v != 4'd0 && len >= 6 && habilita) begin
      e.tem = ($countones(v) == 1);
      e.v   = v;
      e.cyc = inicio + 6;
      fila.push_back(e);
    end
  endtask

  task automatic press(input logic [3:0] v, input int len, input int gap);
    preve(v, len, cyc);
    botoes = v;
    tick(len);
    botoes = 4'd0;
    tick(gap);
  endtask

  task automatic bounce(input logic [3:0] v, input int gap);
    botoes = v;
    tick(2);
    botoes = 4'd0;
    tick(1);
    botoes = v;
    tick(2);
    botoes = 4'd0;
    tick(gap);
  endtask

  // Monitor: compares every pulse with the head of the queue and tracks jogada.
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      #1;
      while (fila.size() > 0 && fila[0].cyc < cyc) begin
        e = fila.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: got none expected %s code %0h at cycle %0d",
                 e.tem ? "tem_jogada" : "multipla", e.v, e.cyc);
      end
      if (tem_jogada || multipla) begin
        chk("pulse_exclusive", {31'd0, tem_jogada & multipla}, 32'd0);
        if (fila.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got tem=%0b mult=%0b expected none (cycle %0d)",
                   tem_jogada, multipla, cyc);
        end else begin
          e = fila.pop_front();
          chk("pulse_kind_tem", {31'd0, tem_jogada}, {31'd0, e.tem});
          chk("pulse_cycle", cyc, e.cyc);
          if (e.tem) ref_jogada = e.v;
        end
      end
      chk("jogada", {28'd0, jogada}, {28'd0, ref_jogada});
    end
  end

  // Watchdog against a hung run.
  initial begin
    #40_000_000;
    $display("FAIL watchdog: got no finish expected finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int cp;
    logic [3:0] v;
    int len;

    reset = 1'b1;
    habilita = 1'b0;
    zera_timeout = 1'b0;
    botoes = 4'd0;
    tick(2);
    #2;
    chk("reset_jogada", {28'd0, jogada}, 32'd0);
    chk("reset_tem", {31'd0, tem_jogada}, 32'd0);
    chk("reset_mult", {31'd0, multipla}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);
    chk("reset_estado", {29'd0, db_estado}, 32'd0);
    reset = 1'b0;

    // Idle with play disabled.
    tick(20);
    #2;
    chk("idle_estado", {29'd0, db_estado}, 32'd0);
    chk("idle_timeout", {31'd0, timeout}, 32'd0);

    // Single clean press, then release.
    habilita = 1'b1;
    press(4'b0100, 10, 10);
    #2;
    chk("after_release_jogada", {28'd0, jogada}, 32'h4);
    chk("after_release_estado", {29'd0, db_estado}, 32'd0);

    // Short glitch and a bounce inside the debounce window.
    press(4'b0010, 2, 8);
    bounce(4'b0010, 8);
    #2;
    chk("glitch_estado", {29'd0, db_estado}, 32'd0);

    // Multi-bit press, then a press while disabled.
    press(4'b1001, 10, 10);
    habilita = 1'b0;
    tick(1);
    press(4'b0001, 10, 10);
    #2;
    chk("disabled_jogada", {28'd0, jogada}, 32'h4);

    // Randomized presses, glitches and bounces.
    for (int i = 0; i < 30; i++) begin
      habilita = ($urandom_range(0, 3) != 0);
      tick(1);
      if ($urandom_range(0, 9) < 6) v = 4'(32'd1 << $urandom_range(0, 3));
      else v = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) begin
        bounce(v, $urandom_range(8, 12));
      end else begin
        if ($urandom_range(0, 2) == 0) len = $urandom_range(1, 3);
        else len = $urandom_range(6, 12);
        press(v, len, $urandom_range(8, 12));
      end
    end

    // Timeout fires exactly TIMEOUT_CYCLES edges after counting starts.
    habilita = 1'b1;
    zera_timeout = 1'b1;
    tick(1);
    zera_timeout = 1'b0;
    c0 = cyc;
    wait_cyc(c0 + 4999);
    chk("timeout_before_terminal", {31'd0, timeout}, 32'd0);
    wait_cyc(c0 + 5000);
    chk("timeout_at_terminal", {31'd0, timeout}, 32'd1);
    wait_cyc(c0 + 5020);
    chk("timeout_sticky", {31'd0, timeout}, 32'd1);

    // Clear, then land a play exactly on the terminal-count cycle.
    tick(1);
    zera_timeout = 1'b1;
    tick(1);
    zera_timeout = 1'b0;
    #2;
    chk("timeout_cleared", {31'd0, timeout}, 32'd0);
    c0 = cyc;
    wait_cyc(c0 + 4993);
    cp = cyc;
    press(4'b0001, 8, 10);
    wait_cyc(cp + 12);
    chk("terminal_play_prevents_timeout", {31'd0, timeout}, 32'd0);
    wait_cyc(cp + 7 + 4999);
    chk("restart_before_terminal", {31'd0, timeout}, 32'd0);
    wait_cyc(cp + 7 + 5000);
    chk("restart_at_terminal", {31'd0, timeout}, 32'd1);
    tick(1);
    zera_timeout = 1'b1;
    tick(1);
    zera_timeout = 1'b0;

    // Reset while waiting for release with a button held.
    tick(2);
    preve(4'b1000, 20, cyc);
    botoes = 4'b1000;
    tick(10);
    #2;
    chk("held_estado", {29'd0, db_estado}, 32'd3);
    reset = 1'b1;
    ref_jogada = 4'd0;
    #2;
    chk("midreset_jogada", {28'd0, jogada}, 32'd0);
    chk("midreset_estado", {29'd0, db_estado}, 32'd0);
    chk("midreset_timeout", {31'd0, timeout}, 32'd0);
    tick(2);
    reset = 1'b0;
    preve(4'b1000, 20, cyc);
    tick(10);
    botoes = 4'd0;
    tick(10);

    #2;
    chk("queue_drained", fila.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
